fsmc_cmd_sched: RTL

Command scheduler that sits directly upstream of the FSMC controller. It buffers single-beat FSMC transaction commands from an AXIS-style slave port, and issues them one at a time over the controller's AP CTRL handshake (start/idle/done). It captures the controller's un-throttled read-data pulse into a read FIFO with ready/valid. Read commands are issued only when read-FIFO space is guaranteed, so no read data is ever dropped.

---
 rtl/fsmc_cmd_sched_if.sv | 21 ++
 rtl/fsmc_cmd_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fsmc_cmd_sched_if.sv
// rtl/fsmc_cmd_sched_if.sv - single-beat FSMC command stream into the scheduler
interface fsmc_cmd_sched_if;
    logic [25:0] s_axis_cmd_addr;
    logic [15:0] s_axis_cmd_wdata;
    logic [1:0]  s_axis_cmd_mask;
    logic        s_axis_cmd_is_rd;
    logic        s_axis_cmd_valid;
    logic        s_axis_cmd_ready;

    modport master (
        output s_axis_cmd_addr, s_axis_cmd_wdata, s_axis_cmd_mask,
        output s_axis_cmd_is_rd, s_axis_cmd_valid,
        input  s_axis_cmd_ready
    );

    modport slave (
        input  s_axis_cmd_addr, s_axis_cmd_wdata, s_axis_cmd_mask,
        input  s_axis_cmd_is_rd, s_axis_cmd_valid,
        output s_axis_cmd_ready
    );
endinterface

// File: rtl/fsmc_cmd_sched.sv
// rtl/fsmc_cmd_sched.sv - in-order FSMC command scheduler with read-data buffering
module fsmc_cmd_sched #(
    parameter real simulation_delay = 0.0,
    parameter int  CMD_FIFO_DEPTH   = 4,
    parameter int  RD_FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fsmc_cmd_sched_if.slave       cmd,
    output logic                  ctrler_start,
    input  logic                  ctrler_idle,
    input  logic                  ctrler_done,
    output logic [25:0]           trans_addr,
    output logic [15:0]           wdata,
    output logic [1:0]            data_mask,
    output logic                  is_rd,
    input  logic [15:0]           ctrl_rd_data,
    input  logic                  ctrl_rd_valid,
    output logic [15:0]           m_axis_rd_data,
    output logic                  m_axis_rd_valid,
    input  logic                  m_axis_rd_ready,
    output logic                  sched_busy,
    output logic                  rd_ovf
);
    localparam int CAW = $clog2(CMD_FIFO_DEPTH);
    localparam int CW  = 26 + 16 + 2 + 1;
    localparam int RIW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int RCW = $clog2(RD_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    if (simulation_delay < 0.0) begin : g_bad_delay
        $error("simulation_delay must be non-negative");
    end
    if (CMD_FIFO_DEPTH < 2 || (CMD_FIFO_DEPTH & (CMD_FIFO_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
        $error("CMD_FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (RD_FIFO_DEPTH < 1 || (RD_FIFO_DEPTH & (RD_FIFO_DEPTH - 1)) != 0) begin : g_bad_rd_depth
        $error("RD_FIFO_DEPTH must be a power of 2 and >= 1");
    end

    logic [CW-1:0]  r_cmd_mem [CMD_FIFO_DEPTH];
    logic [CAW:0]   r_cmd_wptr;
    logic [CAW:0]   r_cmd_rptr;
    logic [CW-1:0]  w_cmd_head;
    logic           w_cmd_empty;
    logic           w_cmd_full;
    logic           w_cmd_push;
    logic           w_cmd_pop;

    logic [15:0]    r_rd_mem [RD_FIFO_DEPTH];
    logic [RIW-1:0] r_rd_wptr;
    logic [RIW-1:0] r_rd_rptr;
    logic [RCW-1:0] r_rd_cnt;
    logic           r_rd_pend;
    logic           r_rd_ovf;
    logic           w_rd_full;
    logic           w_rd_empty;
    logic           w_rd_push;
    logic           w_rd_pop;
    logic [RCW:0]   w_rd_used;

    state_t         r_state;
    logic           w_eligible;

    function automatic logic [RIW-1:0] rd_inc(input logic [RIW-1:0] p);
        return (p == RIW'(RD_FIFO_DEPTH - 1)) ? '0 : p + RIW'(1);
    endfunction

    assign w_cmd_empty = (r_cmd_wptr == r_cmd_rptr);
    assign w_cmd_full  = (r_cmd_wptr[CAW] != r_cmd_rptr[CAW]) &&
                         (r_cmd_wptr[CAW-1:0] == r_cmd_rptr[CAW-1:0]);
    assign w_cmd_push  = cmd.s_axis_cmd_valid & ~w_cmd_full;
    assign w_cmd_pop   = (r_state == ST_ISSUE) & ctrler_idle & ~w_cmd_empty;
    assign w_cmd_head  = r_cmd_mem[r_cmd_rptr[CAW-1:0]];

    assign cmd.s_axis_cmd_ready = ~w_cmd_full;
    assign {trans_addr, wdata, data_mask, is_rd} = w_cmd_head;

    // A read in flight still owns a slot until its data pulse lands, so a
    // data pulse coincident with done can never overrun the read FIFO.
    assign w_rd_used  = {1'b0, r_rd_cnt} + {{RCW{1'b0}}, r_rd_pend};
    assign w_eligible = ~w_cmd_empty &
                        (~w_cmd_head[0] | (w_rd_used < (RCW+1)'(RD_FIFO_DEPTH)));

    assign w_rd_full   = (r_rd_cnt == RCW'(RD_FIFO_DEPTH));
    assign w_rd_empty  = (r_rd_cnt == '0);
    assign w_rd_push   = ctrl_rd_valid & ~w_rd_full;
    assign w_rd_pop    = ~w_rd_empty & m_axis_rd_ready;

    assign m_axis_rd_data  = r_rd_mem[r_rd_rptr];
    assign m_axis_rd_valid = ~w_rd_empty;
    assign rd_ovf          = r_rd_ovf;
    assign ctrler_start    = (r_state == ST_ISSUE);
    assign sched_busy      = ~((r_state == ST_IDLE) & w_cmd_empty);

    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wptr[CAW-1:0]] <= {cmd.s_axis_cmd_addr, cmd.s_axis_cmd_wdata,
                                               cmd.s_axis_cmd_mask, cmd.s_axis_cmd_is_rd};
        end
        if (w_rd_push) begin
            r_rd_mem[r_rd_wptr] <= ctrl_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_wptr <= '0;
            r_cmd_rptr <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + (CAW+1)'(1);
            if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + (CAW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_wptr <= '0;
            r_rd_rptr <= '0;
            r_rd_cnt  <= '0;
            r_rd_ovf  <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_rd_push) r_rd_wptr <= rd_inc(r_rd_wptr);
            if (w_rd_pop)  r_rd_rptr <= rd_inc(r_rd_rptr);
            if (w_rd_push && !w_rd_pop)      r_rd_cnt <= r_rd_cnt + RCW'(1);
            else if (!w_rd_push && w_rd_pop) r_rd_cnt <= r_rd_cnt - RCW'(1);
            if (ctrl_rd_valid && w_rd_full)  r_rd_ovf <= 1'b1;
            if (w_cmd_pop && w_cmd_head[0])  r_rd_pend <= 1'b1;
            else if (ctrl_rd_valid)          r_rd_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (w_eligible) r_state <= ST_ISSUE;
                ST_ISSUE: if (ctrler_idle) r_state <= ST_WAIT;
                ST_WAIT:  if (ctrler_done) r_state <= w_eligible ? ST_ISSUE : ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
